dm_responder: RTL and testbench
===============================

Name: dm_responder

Overview:
- Data-memory responder on the CPU side of the M-stage data bus: the memory end of m_data_addr / m_data_wdata / m_data_byteen / m_data_rdata / m_inst_addr.
- Word-organised RAM with asynchronous read and synchronous byte-enabled write.
- Every committed store is pushed into a trace FIFO drained over a valid/ready port, used by the bench for the "@pc: *addr <= data" store log.
- Sits beside the CPU top; the instruction memory is a separate block.

Parameters:
DEPTH_WORDS, 3072, number of 32-bit words (12 KiB, byte addresses 0x0000-0x2FFF)
LOG_DEPTH, 4, trace FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
m_data_addr  in  32  byte address; bits [1:0] ignored for word select
m_data_wdata  in  32  store data, already lane-aligned by the CPU
m_data_byteen  in  4  byte-lane write enable; 0000 means no write
m_inst_addr  in  32  PC of the M-stage instruction
m_data_rdata  out  32  word at m_data_addr
log_valid  out  1  trace head entry valid
log_ready  in  1  consumer accepts head entry
log_pc  out  32  PC of the head store
log_addr  out  32  word-aligned address of the head store ({addr[31:2],2'b00})
log_data  out  32  full word after the merge
log_count  out  $clog2(LOG_DEPTH)+1  occupied entries
log_overflow  out  1  sticky: a store record was dropped
addr_err  out  1  sticky: out-of-range access seen

Behaviour:
- Reset (reset=0, asynchronous):
  - all RAM words 0; FIFO empty; log_valid=0, log_count=0.
  - log_overflow=0, addr_err=0; log_pc/log_addr/log_data = 0.
  - Reset mid-operation discards all pending records.
- Word index = m_data_addr[31:2]. In range iff index < DEPTH_WORDS.
- Read:
  - Combinational, zero latency: m_data_rdata = RAM[index] if in range, else 0.
  - A same-cycle store does not bypass; read returns the pre-edge word.
- Write ("store"):
  - Occurs when byteen!=0 and the address is in range.
  - At the rising edge, lane i (bits 8i+7:8i) takes wdata lane i where byteen[i]=1; other lanes keep their value.
  - Any byteen pattern is accepted; the CPU guarantees legality.
- Out-of-range access (byteen!=0 or any read) with index >= DEPTH_WORDS:
  - No RAM change, no trace record.
  - addr_err set at the next edge and held until reset.
- Trace push:
  - Each in-range store pushes {m_inst_addr, aligned addr, merged word} at the same edge as the RAM write.
  - The merged word is computed from the pre-edge RAM content and the write lanes, so back-to-back stores to one word chain correctly.
- Trace pop: when log_valid && log_ready at a rising edge.
- FIFO is show-ahead:
  - log_* always present the head entry.
  - A push into an empty FIFO gives log_valid=1 in the cycle after the edge (latency 1).
- Simultaneous push and pop:
  - Both occur; count unchanged.
  - Legal when full: the pop frees a slot.
- Full (count==LOG_DEPTH) with push and no pop: the record is dropped, RAM is still written, log_overflow set (sticky).
- Pop when empty: impossible, since log_valid=0.
- Pointers wrap modulo LOG_DEPTH; log_count ranges 0..LOG_DEPTH.
- log_pc/log_addr/log_data hold their last value when empty; the bench ignores them then.

Test Plan:
- Reset, then read 0x0000 and 0x2FFC -> rdata 0, log_valid=0, log_count=0, flags 0.
- Store pc=0x3004, addr=0x10, wdata=0x12345678, byteen=1111 -> next cycle rdata@0x10 = 0x12345678; log_valid=1, log_pc=0x3004, log_addr=0x10, log_data=0x12345678.
- Word 0x10 = 0x12345678, then two consecutive cycles:
  - byteen=0010, wdata=0x0000AB00 -> log_data 0x1234AB78.
  - byteen=1100, wdata=0xCDEF0000 -> log_data 0xCDEFAB78.
  - RAM word = 0xCDEFAB78.
- log_ready=0, 5 stores with LOG_DEPTH=4:
  - log_count=4, log_overflow=1, 5th store present in RAM.
  - Raise log_ready -> entries drain in order 1..4, log_valid=0 after the 4th pop.
- FIFO full, push and pop in the same cycle -> count stays 4, the new record lands at the tail, log_overflow unchanged.
- Store to 0x3000 (index 3072):
  - RAM unchanged, no record, addr_err=1, rdata=0.
  - Pulse reset low mid-stream -> all flags, count and RAM return to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dm_responder_if.sv
// Data-memory side of the M-stage bus plus the store-trace drain port.
// Trace port handshake: an entry moves when log_valid && log_ready are both high
// at a rising edge. log_valid never depends on log_ready, and the log_* payload
// stays stable while log_valid is high and no pop happens.
interface dm_responder_if #(
  parameter int LOG_DEPTH = 4
);
  logic [31:0]              m_data_addr;
  logic [31:0]              m_data_wdata;
  logic [3:0]               m_data_byteen;
  logic [31:0]              m_inst_addr;
  logic [31:0]              m_data_rdata;
  logic                     log_valid;
  logic                     log_ready;
  logic [31:0]              log_pc;
  logic [31:0]              log_addr;
  logic [31:0]              log_data;
  logic [$clog2(LOG_DEPTH):0] log_count;
  logic                     log_overflow;
  logic                     addr_err;

  modport master (
    output m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, log_ready,
    input  m_data_rdata, log_valid, log_pc, log_addr, log_data, log_count,
           log_overflow, addr_err
  );

  modport slave (
    input  m_data_addr, m_data_wdata, m_data_byteen, m_inst_addr, log_ready,
    output m_data_rdata, log_valid, log_pc, log_addr, log_data, log_count,
           log_overflow, addr_err
  );
endinterface

// File: rtl/dm_responder.sv
// Word-organised data RAM with asynchronous read and byte-enabled write.
// Every in-range store is also pushed into a show-ahead trace FIFO.
module dm_responder #(
    parameter int DEPTH_WORDS = 3072,
    parameter int LOG_DEPTH   = 4
) (
    input logic clk,
    input logic reset,
    dm_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(LOG_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram [DEPTH_WORDS];
    logic [29:0]   word_idx;
    logic          in_range;
    logic [AW-1:0] ram_idx;
    logic [31:0]   cur_word;
    logic [31:0]   merged;
    logic          store;
    logic          unused_lsb;

    logic [31:0]   fifo_pc   [LOG_DEPTH];
    logic [31:0]   fifo_addr [LOG_DEPTH];
    logic [31:0]   fifo_data [LOG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          pop;
    logic          do_push;
    logic          drop;
    logic          overflow_q;
    logic          addr_err_q;

    assign word_idx   = bus.m_data_addr[31:2];
    assign in_range   = word_idx < 30'(DEPTH_WORDS);
    assign ram_idx    = word_idx[AW-1:0];
    assign unused_lsb = ^bus.m_data_addr[1:0];

    // Read sees the pre-edge word; a same-cycle store is not bypassed.
    assign cur_word = in_range ? ram[ram_idx] : '0;
    assign store    = in_range && (bus.m_data_byteen != 4'b0000);

    always_comb begin
        merged = cur_word;
        for (int i = 0; i < 4; i++) begin
            if (bus.m_data_byteen[i]) merged[8*i +: 8] = bus.m_data_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) ram[i] <= '0;
        end else if (store) begin
            ram[ram_idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) addr_err_q <= 1'b0;
        else if (!in_range) addr_err_q <= 1'b1;
    end

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign full    = (count == CW'(LOG_DEPTH));
    assign pop     = (count != '0) && bus.log_ready;
    assign do_push = store && (!full || pop);
    assign drop    = store && full && !pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LOG_DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_addr[i] <= '0;
                fifo_data[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                fifo_pc[wr_ptr]   <= bus.m_inst_addr;
                fifo_addr[wr_ptr] <= {bus.m_data_addr[31:2], 2'b00};
                fifo_data[wr_ptr] <= merged;
                wr_ptr            <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign bus.m_data_rdata = cur_word;
    assign bus.log_valid    = (count != '0);
    assign bus.log_pc       = fifo_pc[rd_ptr];
    assign bus.log_addr     = fifo_addr[rd_ptr];
    assign bus.log_data     = fifo_data[rd_ptr];
    assign bus.log_count    = count;
    assign bus.log_overflow = overflow_q;
    assign bus.addr_err     = addr_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: reset, stores, lane merge, trace FIFO
// full/overflow behaviour, out-of-range access and asynchronous reset.
module tb_dm_responder;
  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  dm_responder_if #(.LOG_DEPTH(4)) bus ();

  dm_responder #(.DEPTH_WORDS(3072), .LOG_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic store(input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    bus.m_inst_addr   = pc;
    bus.m_data_addr   = addr;
    bus.m_data_wdata  = data;
    bus.m_data_byteen = be;
    @(posedge clk);
    #1;
    bus.m_data_byteen = 4'b0000;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.m_data_addr = 32'h0; bus.m_data_wdata = 32'h0; bus.m_data_byteen = 4'h0;
    bus.m_inst_addr = 32'h0; bus.log_ready = 1'b0;
    #1;
    vectors++; if (bus.m_data_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata0 got %h exp 0", bus.m_data_rdata); end
    bus.m_data_addr = 32'h2FFC;
    #1;
    vectors++; if (bus.m_data_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_rdata2ffc got %h exp 0", bus.m_data_rdata); end
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", bus.log_valid); end
    vectors++; if (bus.log_count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", bus.log_count); end
    vectors++; if ({bus.log_overflow, bus.addr_err} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b exp 00", {bus.log_overflow, bus.addr_err}); end
    @(negedge clk);
    reset = 1'b1;
    bus.m_data_addr = 32'h0;
    @(posedge clk); #1;
    vectors++; if (bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL reset_release_err got %b exp 0", bus.addr_err); end
  endtask

  task automatic test_full_store();
    store(32'h3004, 32'h10, 32'h12345678, 4'b1111);
    vectors++; if (bus.m_data_rdata !== 32'h12345678) begin miscompares++; $display("FAIL store_rdata got %h exp 12345678", bus.m_data_rdata); end
    vectors++; if (bus.log_valid !== 1'b1) begin miscompares++; $display("FAIL store_valid got %b exp 1", bus.log_valid); end
    vectors++; if (bus.log_pc !== 32'h3004) begin miscompares++; $display("FAIL store_pc got %h exp 3004", bus.log_pc); end
    vectors++; if (bus.log_addr !== 32'h10) begin miscompares++; $display("FAIL store_addr got %h exp 10", bus.log_addr); end
    vectors++; if (bus.log_data !== 32'h12345678) begin miscompares++; $display("FAIL store_data got %h exp 12345678", bus.log_data); end
    bus.log_ready = 1'b1;
    @(posedge clk); #1;
    bus.log_ready = 1'b0;
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL store_drain_valid got %b exp 0", bus.log_valid); end
  endtask

  task automatic test_back_to_back_merge();
    store(32'h3008, 32'h11, 32'h0000AB00, 4'b0010);
    store(32'h300C, 32'h12, 32'hCDEF0000, 4'b1100);
    bus.m_data_addr = 32'h10;
    #1;
    vectors++; if (bus.m_data_rdata !== 32'hCDEFAB78) begin miscompares++; $display("FAIL merge_ram got %h exp cdefab78", bus.m_data_rdata); end
    vectors++; if (bus.log_count !== 3'd2) begin miscompares++; $display("FAIL merge_count got %0d exp 2", bus.log_count); end
    vectors++; if (bus.log_data !== 32'h1234AB78) begin miscompares++; $display("FAIL merge_first got %h exp 1234ab78", bus.log_data); end
    vectors++; if (bus.log_addr !== 32'h10) begin miscompares++; $display("FAIL merge_addr got %h exp 10", bus.log_addr); end
    bus.log_ready = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.log_data !== 32'hCDEFAB78) begin miscompares++; $display("FAIL merge_second got %h exp cdefab78", bus.log_data); end
    vectors++; if (bus.log_pc !== 32'h300C) begin miscompares++; $display("FAIL merge_pc got %h exp 300c", bus.log_pc); end
    @(posedge clk); #1;
    bus.log_ready = 1'b0;
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL merge_empty got %b exp 0", bus.log_valid); end
  endtask

  task automatic test_push_pop_full();
    for (int k = 1; k <= 4; k++)
      store(32'h5000 + 32'(4*k), 32'h100 + 32'(4*k), 32'hA5A50000 + 32'(k), 4'b1111);
    vectors++; if (bus.log_count !== 3'd4) begin miscompares++; $display("FAIL pp_fill_count got %0d exp 4", bus.log_count); end
    bus.log_ready = 1'b1;
    store(32'h5014, 32'h114, 32'hA5A50005, 4'b1111);
    bus.log_ready = 1'b0;
    vectors++; if (bus.log_count !== 3'd4) begin miscompares++; $display("FAIL pp_count got %0d exp 4", bus.log_count); end
    vectors++; if (bus.log_overflow !== 1'b0) begin miscompares++; $display("FAIL pp_overflow got %b exp 0", bus.log_overflow); end
    bus.log_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      vectors++; if (bus.log_data !== 32'hA5A50000 + 32'(k)) begin miscompares++; $display("FAIL pp_drain%0d_data got %h exp %h", k, bus.log_data, 32'hA5A50000 + 32'(k)); end
      vectors++; if (bus.log_addr !== 32'h100 + 32'(4*k)) begin miscompares++; $display("FAIL pp_drain%0d_addr got %h exp %h", k, bus.log_addr, 32'h100 + 32'(4*k)); end
      @(posedge clk); #1;
    end
    bus.log_ready = 1'b0;
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL pp_empty got %b exp 0", bus.log_valid); end
  endtask

  task automatic test_overflow();
    for (int k = 1; k <= 5; k++)
      store(32'h6000 + 32'(4*k), 32'h200 + 32'(4*k), 32'hB0000000 + 32'(k), 4'b1111);
    vectors++; if (bus.log_count !== 3'd4) begin miscompares++; $display("FAIL ovf_count got %0d exp 4", bus.log_count); end
    vectors++; if (bus.log_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag got %b exp 1", bus.log_overflow); end
    vectors++; if (bus.m_data_rdata !== 32'hB0000005) begin miscompares++; $display("FAIL ovf_ram5 got %h exp b0000005", bus.m_data_rdata); end
    bus.log_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      vectors++; if (bus.log_pc !== 32'h6000 + 32'(4*k)) begin miscompares++; $display("FAIL ovf_drain%0d_pc got %h exp %h", k, bus.log_pc, 32'h6000 + 32'(4*k)); end
      vectors++; if (bus.log_data !== 32'hB0000000 + 32'(k)) begin miscompares++; $display("FAIL ovf_drain%0d_data got %h exp %h", k, bus.log_data, 32'hB0000000 + 32'(k)); end
      @(posedge clk); #1;
    end
    bus.log_ready = 1'b0;
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_empty got %b exp 0", bus.log_valid); end
    vectors++; if (bus.log_overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky got %b exp 1", bus.log_overflow); end
  endtask

  task automatic test_out_of_range();
    vectors++; if (bus.addr_err !== 1'b0) begin miscompares++; $display("FAIL oor_pre_err got %b exp 0", bus.addr_err); end
    store(32'h7000, 32'h3000, 32'hDEADBEEF, 4'b1111);
    vectors++; if (bus.addr_err !== 1'b1) begin miscompares++; $display("FAIL oor_err got %b exp 1", bus.addr_err); end
    vectors++; if (bus.m_data_rdata !== 32'h0) begin miscompares++; $display("FAIL oor_rdata got %h exp 0", bus.m_data_rdata); end
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL oor_record got %b exp 0", bus.log_valid); end
    bus.m_data_addr = 32'h0;
    #1;
    vectors++; if (bus.m_data_rdata !== 32'h0) begin miscompares++; $display("FAIL oor_alias0 got %h exp 0", bus.m_data_rdata); end
    @(posedge clk); #1;
    vectors++; if (bus.addr_err !== 1'b1) begin miscompares++; $display("FAIL oor_sticky got %b exp 1", bus.addr_err); end
  endtask

  task automatic test_async_reset();
    store(32'h8000, 32'h40, 32'h0BADF00D, 4'b1111);
    vectors++; if (bus.log_count !== 3'd1) begin miscompares++; $display("FAIL ar_pre_count got %0d exp 1", bus.log_count); end
    #1;
    reset = 1'b0;
    #1;
    vectors++; if (bus.m_data_rdata !== 32'h0) begin miscompares++; $display("FAIL ar_ram40 got %h exp 0", bus.m_data_rdata); end
    vectors++; if (bus.log_count !== 3'd0) begin miscompares++; $display("FAIL ar_count got %0d exp 0", bus.log_count); end
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got %b exp 0", bus.log_valid); end
    vectors++; if ({bus.log_overflow, bus.addr_err} !== 2'b00) begin miscompares++; $display("FAIL ar_flags got %b exp 00", {bus.log_overflow, bus.addr_err}); end
    bus.m_data_addr = 32'h10;
    #1;
    vectors++; if (bus.m_data_rdata !== 32'h0) begin miscompares++; $display("FAIL ar_ram10 got %h exp 0", bus.m_data_rdata); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++; if (bus.log_valid !== 1'b0) begin miscompares++; $display("FAIL ar_after_valid got %b exp 0", bus.log_valid); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_full_store();
    test_back_to_back_merge();
    test_push_pop_full();
    test_overflow();
    test_out_of_range();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
